zeroriscy_bnn_array: RTL
========================

# zeroriscy_bnn_array

Parametrised binarised-neural-network execution unit attached to the zero-riscy EX stage. It holds N_NEURON neuron lanes. Each lane runs an XNOR-popcount accumulator, a max-pool register and a batch-norm threshold, all fed from an external synchronous weight RAM. It returns the sign-bit activation vector in 32-bit words through a ready/enable command handshake. The unit scales in lane count, input width and accumulator width, saturates its arithmetic, and provides multi-word result readout.

## Interface
- N_NEURON, 32: number of neuron lanes; must be a multiple of 32.
- DATA_W, 32: width of the activation input and of each lane's weight word; 32 maximum.
- ACC_W, 16: signed accumulator/pool width; at least $clog2(DATA_W)+3.
- NORM_SHIFT, 6: left shift applied to pool before threshold subtraction.
- clk  in  1  clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- bnn_en_i  in  1  command valid.
- bnn_operator_i  in  3  opcode: 0 INI, 1 ACC, 2 POOL, 3 NORM, 4 ACTIV, 5-7 NOP.
- bnn_addr_i  in  32  weight-RAM address, or result word index for ACTIV.
- bnn_data_i  in  32  activation operand; bits [DATA_W-1:0] are used.
- bnn_ready_o  out  1  unit can accept a command this cycle.
- bnn_result_o  out  32  selected activation word.
- param_addr_o  out  16  weight-RAM address; combinational copy of bnn_addr_i[15:0].
- param_i  in  N_NEURON*DATA_W  weight-RAM read data, valid one cycle after the address. Lane g uses [DATA_W*g +: DATA_W].

## Operation
- A command is accepted on a rising edge where bnn_en_i && bnn_ready_o. In any other cycle a bubble (NOP) enters the pipeline.
- Stage 0 (accept edge T): register the opcode, the data and the result word index. The external RAM registers param_addr_o.
- Stage 1 (edge T+1), per lane, register an operand word x:
  - INI, POOL: x = data.
  - ACC: x = ~(data ^ w).
  - NORM: x = w.
  - Other opcodes: x is don't-care.
- Stage 2 (edge T+2), per lane:
  - INI: acc = sign-extended x[min(DATA_W,ACC_W)-1:0]; pool = most-negative ACC_W value.
  - ACC: acc = sat(acc + 2*popcount(x)).
  - POOL: if acc > pool (signed), pool = acc. acc = x, loaded as in INI. Both use the pre-edge values.
  - NORM: pool = sat((pool <<< NORM_SHIFT) - sext(x[ACC_W-1:0])). Compute at ACC_W+NORM_SHIFT+1 bits, then clamp to the ACC_W signed range.
  - NOP / ACTIV: acc and pool unchanged.
- sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and never wraps.
- Lane activation: activ[g] = pool[ACC_W-1], i.e. 1 when pool is negative.
- ACTIV:
  - Word index k = bnn_addr_i[$clog2(N_NEURON/32)-1:0]; this is 0 when N_NEURON = 32.
  - The result register captures activ[32k+31:32k] once all older commands have retired.
  - bnn_result_o holds that value until the next ACTIV capture.

## Timing
- ACC/INI/POOL/NORM are fully pipelined: one per cycle, back-to-back, with bnn_ready_o staying high. An op accepted at T is visible in acc/pool after edge T+2.
- ACTIV accepted at T:
  - bnn_ready_o goes low from after edge T until edge T+2.
  - Result capture happens at edge T+2, after the final update of the op accepted at T-1.
  - bnn_result_o is valid and bnn_ready_o is high again from edge T+2.
  - A command accepted at T+2 does not affect the captured value.
- bnn_en_i while bnn_ready_o is low is ignored. The core must hold the request; the unit does not queue it.
- Reset (asynchronous, any time, including mid-pipeline or mid-ACTIV):
  - bnn_ready_o = 1, bnn_result_o = 0.
  - Pipeline stages become NOP.
  - acc = 0; pool = most-negative value, so activ = 1 for every lane.
  - No in-flight command completes after reset.
- param_addr_o is combinational; the weight RAM has exactly one cycle read latency.

## Test plan
- Reset, then ACTIV k=0 -> bnn_ready_o low for 2 cycles, then bnn_result_o = 32'hFFFF_FFFF.
- INI data=0; ACC with data = all-ones and w = all-ones (DATA_W=32); POOL data=0; NORM w=0; ACTIV -> acc reached 64, pool = 64<<6 = 4096, and the activation bit is 0 in every lane.
- Saturation (ACC_W=16): INI data=16'h7FF0, then ACC with 64 per lane -> acc = 16'h7FFF with no wrap; NORM with pool=30000 -> pool = 16'h7FFF.
- POOL sequence with acc values 5, -3, 9 on consecutive back-to-back cycles -> pool = 9. Every command is accepted with bnn_ready_o high, and the pipeline has no stall.
- N_NEURON=64: set lanes 32-63 negative and lanes 0-31 positive; ACTIV k=1 -> 32'hFFFF_FFFF; ACTIV k=0 -> 32'h0.
- Assert rst_n low during the cycle after ACTIV is accepted -> bnn_ready_o = 1 immediately and bnn_result_o = 0. A NORM issued just before reset leaves pool at its reset value.

Source files
------------

// File: rtl/zeroriscy_bnn_array.sv
// zeroriscy_bnn_array: binarised NN execution unit for the zero-riscy EX stage.
// Three stages: command register, per-lane operand (XNOR/weight) register, acc/pool update.
module zeroriscy_bnn_array #(
    parameter int unsigned N_NEURON   = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned NORM_SHIFT = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bnn_en_i,
    input  logic [2:0]                 bnn_operator_i,
    input  logic [31:0]                bnn_addr_i,
    input  logic [31:0]                bnn_data_i,
    output logic                       bnn_ready_o,
    output logic [31:0]                bnn_result_o,
    output logic [15:0]                param_addr_o,
    input  logic [N_NEURON*DATA_W-1:0] param_i
);

    localparam logic [2:0] OpIni   = 3'd0;
    localparam logic [2:0] OpAcc   = 3'd1;
    localparam logic [2:0] OpPool  = 3'd2;
    localparam logic [2:0] OpNorm  = 3'd3;
    localparam logic [2:0] OpActiv = 3'd4;
    localparam logic [2:0] OpNop   = 3'd7;

    localparam int unsigned NWords = N_NEURON / 32;
    localparam int unsigned IdxW   = (NWords > 1) ? $clog2(NWords) : 1;
    localparam int unsigned LdW    = (DATA_W < ACC_W) ? DATA_W : ACC_W;
    localparam int unsigned NormW  = ACC_W + NORM_SHIFT + 1;

    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};

    logic              accept;
    logic [IdxW-1:0]   cmd_idx;
    logic [2:0]        s0_op_q;
    logic [DATA_W-1:0] s0_data_q;
    logic [IdxW-1:0]   s0_idx_q;
    logic [2:0]        s1_op_q;
    logic [IdxW-1:0]   s1_idx_q;
    logic [31:0]       result_q;
    logic [31:0]       sel_word;
    logic [N_NEURON-1:0] activ;
    logic              unused_inputs;

    assign unused_inputs = ^{bnn_addr_i[31:16], bnn_data_i};

    if (NWords > 1) begin : gen_idx
        assign cmd_idx = bnn_addr_i[IdxW-1:0];
    end else begin : gen_idx_zero
        assign cmd_idx = '0;
    end

    assign param_addr_o = bnn_addr_i[15:0];
    // ACTIV blocks new commands until it reaches the capture point in stage 2.
    assign bnn_ready_o  = (s0_op_q != OpActiv) && (s1_op_q != OpActiv);
    assign accept       = bnn_en_i && bnn_ready_o;
    assign bnn_result_o = result_q;

    always_comb begin
        sel_word = '0;
        for (int w = 0; w < NWords; w++) begin
            if (s1_idx_q == IdxW'(w)) begin
                sel_word = activ[32*w +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_op_q   <= OpNop;
            s0_data_q <= '0;
            s0_idx_q  <= '0;
            s1_op_q   <= OpNop;
            s1_idx_q  <= '0;
            result_q  <= '0;
        end else begin
            s0_op_q <= accept ? bnn_operator_i : OpNop;
            if (accept) begin
                s0_data_q <= bnn_data_i[DATA_W-1:0];
                s0_idx_q  <= cmd_idx;
            end
            s1_op_q  <= s0_op_q;
            s1_idx_q <= s0_idx_q;
            // Pool here already holds every older command's final update.
            if (s1_op_q == OpActiv) begin
                result_q <= sel_word;
            end
        end
    end

    for (genvar g = 0; g < N_NEURON; g++) begin : gen_lane
        logic [DATA_W-1:0]       w;
        logic [DATA_W-1:0]       x_d;
        logic [DATA_W-1:0]       x_q;
        logic signed [LdW-1:0]   x_lo;
        logic signed [ACC_W-1:0] ld;
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] acc_d;
        logic signed [ACC_W-1:0] pool_q;
        logic signed [ACC_W-1:0] pool_d;
        logic [ACC_W:0]          pc2;
        logic [ACC_W:0]          sum;
        logic signed [NormW-1:0] norm;
        logic [NORM_SHIFT+1:0]   norm_top;

        assign w = param_i[DATA_W*g +: DATA_W];

        always_comb begin
            case (s0_op_q)
                OpAcc:   x_d = ~(s0_data_q ^ w);
                OpNorm:  x_d = w;
                default: x_d = s0_data_q;
            endcase
        end

        always_comb begin
            x_lo = x_q[LdW-1:0];
            ld   = ACC_W'(x_lo);
            pc2  = '0;
            for (int i = 0; i < DATA_W; i++) begin
                pc2 = pc2 + (ACC_W+1)'(x_q[i]);
            end
            pc2      = pc2 << 1;
            sum      = {acc_q[ACC_W-1], acc_q} + pc2;
            norm     = (NormW'(pool_q) <<< NORM_SHIFT) - NormW'(ld);
            norm_top = norm[NormW-1:ACC_W-1];

            acc_d  = acc_q;
            pool_d = pool_q;
            case (s1_op_q)
                OpIni: begin
                    acc_d  = ld;
                    pool_d = AccMin;
                end
                OpAcc: begin
                    if (sum[ACC_W] != sum[ACC_W-1]) begin
                        acc_d = sum[ACC_W] ? AccMin : AccMax;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
                OpPool: begin
                    if (acc_q > pool_q) begin
                        pool_d = acc_q;
                    end
                    acc_d = ld;
                end
                OpNorm: begin
                    // Result fits only if all bits above the ACC_W sign bit match it.
                    if ((&norm_top) || !(|norm_top)) begin
                        pool_d = norm[ACC_W-1:0];
                    end else begin
                        pool_d = norm[NormW-1] ? AccMin : AccMax;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q    <= '0;
                acc_q  <= '0;
                pool_q <= AccMin;
            end else begin
                x_q    <= x_d;
                acc_q  <= acc_d;
                pool_q <= pool_d;
            end
        end

        assign activ[g] = pool_q[ACC_W-1];
    end

endmodule
